// File: rtl/lcd_scan_pkg.sv
// Shared types and sizing for the LCD scan-out block.
package lcd_scan_pkg;

  localparam int unsigned IMG_DIM_DEF = 8;
  localparam int unsigned PIX_CNT     = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } scan_state_e;

endpackage

// File: rtl/pix_skid_buf.sv
// Output buffer: one presented entry plus a 2-entry skid behind it.
// The presented register only changes when empty or accepted, so the panel
// side sees stable data while stalled. level_c_o is the skid occupancy after
// the coming edge, used upstream for read credit.
module pix_skid_buf #(
  parameter int unsigned W = 10
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         in_ready_c_o,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  input  logic         out_ready_i,
  output logic [1:0]   level_c_o
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic [W-1:0] s0_q, s0_d;
  logic [W-1:0] s1_q, s1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         push;
  logic         load_out;

  // Next-state for the presented register and the skid entries
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    s0_d        = s0_q;
    s1_d        = s1_q;
    cnt_d       = cnt_q;
    push        = in_valid_i && (cnt_q != 2'd2);
    load_out    = !out_valid_q || out_ready_i;
    if (load_out) begin
      if (cnt_q != 2'd0) begin
        out_valid_d = 1'b1;
        out_data_d  = s0_q;
        s0_d        = s1_q;
        if (push) begin
          if (cnt_q == 2'd1) s0_d = in_data_i;
          else               s1_d = in_data_i;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end else begin
        out_valid_d = push;
        if (push) out_data_d = in_data_i;
      end
    end else if (push) begin
      if (cnt_q == 2'd0) s0_d = in_data_i;
      else               s1_d = in_data_i;
      cnt_d = cnt_q + 2'd1;
    end
  end

  // Buffer registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      s0_q        <= '0;
      s1_q        <= '0;
      cnt_q       <= 2'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready_c_o = (cnt_q != 2'd2);
  assign level_c_o    = cnt_d;
  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;

endmodule

// File: rtl/lcd_scan_out.sv
// Streams a finished IMG_DIM x IMG_DIM image buffer to the panel driver in
// row-major order over a valid/ready link, tagging row starts and frame end.
// Optional build macro SCAN_CHECKSUM_EN adds a 16-bit frame checksum output.
module lcd_scan_out
  import lcd_scan_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned IMG_DIM = IMG_DIM_DEF
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       start,
  output logic                                       IRB_EN,
  output logic [$clog2(IMG_DIM*IMG_DIM)-1:0]         IRB_A,
  input  logic [DATA_W-1:0]                          IRB_Q,
  output logic [DATA_W-1:0]                          pix_data,
  output logic                                       pix_valid,
  input  logic                                       pix_ready,
  output logic                                       pix_sol,
  output logic                                       pix_eof,
  output logic                                       busy
`ifdef SCAN_CHECKSUM_EN
  ,
  output logic [15:0]                                frame_sum,
  output logic                                       sum_valid
`endif
);

  localparam int unsigned PIX_N  = IMG_DIM * IMG_DIM;
  localparam int unsigned ADDR_W = $clog2(PIX_N);
  localparam int unsigned ENT_W  = DATA_W + 2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX_N - 1);

  scan_state_e       state_q, state_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] nxt_q, nxt_d;
  logic              land_q, land_d;
  logic [ADDR_W-1:0] land_addr_q, land_addr_d;
  logic              busy_q, busy_d;

  logic              land_sol;
  logic              land_eof;
  logic              buf_in_ready;
  logic              buf_out_valid;
  logic [ENT_W-1:0]  buf_out_data;
  logic [1:0]        buf_level;
  logic              can_issue;
  logic              xfer;
  logic              eof_xfer;

  assign land_sol = ((32'(land_addr_q) % IMG_DIM) == 32'd0);
  assign land_eof = (land_addr_q == LAST_ADDR);
  assign xfer     = buf_out_valid && pix_ready;
  assign eof_xfer = xfer && buf_out_data[DATA_W];
  // Skid entries after this edge plus the read still on the bus must stay below 2
  assign can_issue = buf_in_ready && (({1'b0, buf_level} + {2'b00, rd_q}) < 3'd2);

  // Scan FSM next-state, read issue and address sequencing
  always_comb begin
    state_d     = state_q;
    rd_d        = 1'b0;
    addr_d      = addr_q;
    nxt_d       = nxt_q;
    busy_d      = busy_q;
    land_d      = rd_q;
    land_addr_d = rd_q ? addr_q : land_addr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          rd_d    = 1'b1;
          addr_d  = '0;
          nxt_d   = ADDR_W'(1);
          busy_d  = 1'b1;
        end
      end
      FETCH: begin
        if (can_issue) begin
          rd_d   = 1'b1;
          addr_d = nxt_q;
          if (nxt_q == LAST_ADDR) state_d = DRAIN;
          else                    nxt_d   = nxt_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (eof_xfer) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      nxt_q       <= '0;
      land_q      <= 1'b0;
      land_addr_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      nxt_q       <= nxt_d;
      land_q      <= land_d;
      land_addr_q <= land_addr_d;
      busy_q      <= busy_d;
    end
  end

  pix_skid_buf #(
    .W (ENT_W)
  ) u_buf (
    .clk_i        (clk),
    .rst_n_i      (reset),
    .in_valid_i   (land_q),
    .in_data_i    ({land_sol, land_eof, IRB_Q}),
    .in_ready_c_o (buf_in_ready),
    .out_valid_o  (buf_out_valid),
    .out_data_o   (buf_out_data),
    .out_ready_i  (pix_ready),
    .level_c_o    (buf_level)
  );

  assign IRB_EN    = ~rd_q;
  assign IRB_A     = addr_q;
  assign busy      = busy_q;
  assign pix_valid = buf_out_valid;
  assign pix_data  = buf_out_data[DATA_W-1:0];
  assign pix_eof   = buf_out_data[DATA_W];
  assign pix_sol   = buf_out_data[DATA_W+1];

`ifdef SCAN_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;
  logic        sum_valid_q, sum_valid_d;

  // Checksum accumulates every transferred pixel, cleared on accepted start
  always_comb begin
    sum_d       = sum_q;
    sum_valid_d = eof_xfer;
    if (state_q == IDLE && start) sum_d = 16'd0;
    else if (xfer)                sum_d = sum_q + 16'(pix_data);
  end

  // Checksum registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q       <= 16'd0;
      sum_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  assign frame_sum = sum_q;
  assign sum_valid = sum_valid_q;
`endif

endmodule

// File: doc/lcd_scan_out.md
LCD_SCAN_OUT -- requirements
Module: lcd_scan_out

Interface
REQ-001 SHALL have parameter DATA_W, default 8, pixel width in bits.
REQ-002 SHALL have parameter IMG_DIM, default 8, image side in pixels (8x8 = 64 pixels, 6-bit address).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse from LCD_CTRL done; buffer contents final.
REQ-006 SHALL have port IRB_EN  output  1  active-low read enable to image buffer.
REQ-007 SHALL have port IRB_A  output  6  read address, row-major (row*IMG_DIM+col).
REQ-008 SHALL have port IRB_Q  input  DATA_W  read data, valid the cycle after IRB_EN low.
REQ-009 SHALL have port pix_data  output  DATA_W  pixel to panel driver.
REQ-010 SHALL have port pix_valid  output  1  pix_data valid.
REQ-011 SHALL have port pix_ready  input  1  panel accepts; transfer when valid&&ready.
REQ-012 SHALL have port pix_sol  output  1  qualifies pix_data as column 0 of a row.
REQ-013 SHALL have port pix_eof  output  1  qualifies pix_data as pixel 63.
REQ-014 SHALL have port busy  output  1  high from accepted start to last transfer.

Function
REQ-015 SHALL implement FSM IDLE -> FETCH (start in IDLE) -> DRAIN (address 63 issued) -> IDLE (pixel 63 transferred).
REQ-016 SHALL ignore start when not IDLE; no restart, no counter change.
REQ-017 SHALL drive IRB_EN low only if the output buffer holds fewer than 2 entries counting in-flight reads; never over-read.
REQ-018 SHALL issue address 0 the cycle after start is sampled; first pix_valid 2 cycles after start edge.
REQ-019 SHALL sustain 1 pixel/cycle with pix_ready held high: 64 transfers in 64 consecutive cycles.
REQ-020 SHALL hold pix_data, pix_sol, pix_eof stable while pix_valid && !pix_ready; no drop, no duplicate.
REQ-021 SHALL accept pix_ready low before first pixel with no data loss.
REQ-022 SHALL assert busy the cycle after start accepted; deassert the cycle after pixel-63 transfer.
REQ-023 SHALL advance the 6-bit address counter without wrap; address 63 is final.

Reset
REQ-024 SHALL on reset low immediately force: state IDLE, IRB_EN=1, IRB_A=0, pix_data=0, pix_valid=0, pix_sol=0, pix_eof=0, busy=0, buffer empty.
REQ-025 SHALL abandon a frame on reset mid-operation; next start after release scans from address 0.

Configuration
REQ-026 SHALL with macro SCAN_CHECKSUM_EN defined add outputs frame_sum[15:0] (sum of 64 transferred pixels) and sum_valid (one-cycle pulse the cycle after pixel-63 transfer); frame_sum cleared on accepted start.
REQ-027 SHALL without SCAN_CHECKSUM_EN omit frame_sum, sum_valid and the accumulator; all other behaviour identical.

Structure
REQ-028 SHALL place state enum (IDLE/FETCH/DRAIN), IMG_DIM default and PIX_CNT=64 in package lcd_scan_pkg.
REQ-029 SHALL implement the 2-entry output buffer as sub-module pix_skid_buf (data+sol+eof, valid/ready both sides).

Verification
REQ-030 SHALL cover: mem[k]=k, pix_ready=1, start -> pixels 0x00..0x3F in 64 consecutive cycles, sol at 0,8,...,56, eof at 0x3F only.
REQ-031 SHALL cover: pix_ready low 3 cycles while pix_data=0x0A -> 0x0A held, next transfer 0x0B, total 64 transfers.
REQ-032 SHALL cover: start pulse at pixel 30 while busy -> ignored, stream continues 31..63, single eof.
REQ-033 SHALL cover: reset low at pixel 20 -> pix_valid=0, busy=0 immediately; next start -> first pixel 0x00.
REQ-034 SHALL cover: pix_ready random 50% -> 64 pixels in order, IRB_EN never low with 2 buffered entries.
REQ-035 SHALL cover (SCAN_CHECKSUM_EN): mem[k]=k -> frame_sum=2016 (0x07E0) with one sum_valid pulse.
